inst_fetch: RTL and testbench
=============================

# inst_fetch

Byte-serial instruction fetch and pre-decode stage sitting directly upstream of the ALU. Reads x86 code bytes from a byte-wide memory port and determines instruction length from the opcode. Packs each instruction into the 32-bit `ope` word (opcode in bits 31:24) plus a 32-bit `immidiate_data` word, and hands the pair to the execute stage over a valid/ready handshake. Accepts a redirect (call/ret/jump target) that flushes in-progress work.

## Interface
- `RESET_EIP`, default 32'h0000_0000: fetch address after reset.
- `clock` in 1: single clock, all state on rising edge.
- `reset_n` in 1: asynchronous, active-low reset.
- `mem_req` out 1: byte read request.
- `mem_addr` out 32: byte address; held stable while `mem_req` is high and unacked, except on redirect.
- `mem_ack` in 1: read complete; `mem_rdata` is valid in the same cycle.
- `mem_rdata` in 8: read byte.
- `redirect` in 1: flush and restart fetch.
- `redirect_addr` in 32: new fetch address.
- `ope` out 32: {b0, b1, b2, b3}; bytes beyond the instruction length are 0.
- `immidiate_data` out 32: immediate operand; see Operation.
- `inst_len` out 3: instruction length, 1..5.
- `inst_eip` out 32: address of b0.
- `next_eip` out 32: `inst_eip + inst_len`, mod 2^32.
- `illegal` out 1: opcode not in the length table.
- `ope_valid` out 1: output bundle valid.
- `ope_ready` in 1: consumer accepts. The transfer occurs on a rising edge with `ope_valid` and `ope_ready` both high.

## Operation
- Length table, keyed on b0:
  - 55, 5d, c3, 90 → 1 byte
  - 89 → 2 bytes
  - 83 → 3 bytes
  - b8, e8 → 5 bytes
  - anything else → 1 byte with `illegal`=1
- Immediate packing:
  - b8 / e8: `immidiate_data` = {b4, b3, b2, b1} (little-endian imm32 / rel32).
  - 83: `immidiate_data` = b2 sign-extended to 32 bits.
  - All other opcodes: 0.
- Addresses increment and wrap mod 2^32. A 5-byte instruction at FFFF_FFFF reads FFFF_FFFF, 0, 1, 2, 3.
- FSM without prefetch (states IDLE, FETCH, HOLD):
  - IDLE: occupies exactly 1 cycle after reset release, then goes to FETCH.
  - FETCH: `mem_req`=1. On each ack, capture byte k and increment the address. After the byte that completes `inst_len` (known after b0), register all outputs, set `ope_valid`=1, and go to HOLD.
  - HOLD: `mem_req`=0, outputs stable. On handshake, set `ope_valid`=0, set `mem_addr`=`next_eip`, and go to FETCH.
- Redirect has priority over everything. On an edge with `redirect`=1:
  - All captured or queued bytes are discarded, and an ack in the same cycle is discarded.
  - `ope_valid`=0 next cycle.
  - `mem_addr`=`redirect_addr` next cycle with `mem_req`=1; state goes to FETCH.
  - If a handshake occurs in the same cycle, that instruction counts as delivered.
- `ope_valid` never depends combinationally on `ope_ready`.

## Timing
- Reset values:
  - `mem_req`=0, `ope_valid`=0, `illegal`=0
  - `mem_addr`=`inst_eip`=`next_eip`=`RESET_EIP`
  - `ope`=0, `immidiate_data`=0, `inst_len`=0
- First `mem_req` is asserted in the 2nd cycle after `reset_n` deasserts.
- Assertion of `reset_n` mid-fetch returns everything to reset values immediately.
- Memory handshake:
  - Zero-wait acks (ack in the same cycle as req) are legal.
  - `mem_req` may stay high across consecutive acks, with the address advancing each ack.
- Latency without prefetch, zero-wait memory:
  - An n-byte instruction drives `ope_valid` n cycles after its first `mem_req` cycle.
  - Steady-state throughput for 1-byte instructions is one per 2 cycles.

## Configuration
- `FETCH_PREFETCH_EN` defined:
  - Adds an 8-byte FIFO. The fetcher requests whenever FIFO count plus in-flight bytes is less than 8, independent of the output handshake.
  - Output fields decode combinationally from the FIFO head registers. `ope_valid`=1 when the count is at least the head instruction's length.
  - A handshake pops `inst_len` bytes. A simultaneous pop and push in the same cycle is legal.
  - Sustains 1 instruction per cycle when the FIFO is fed.
  - Redirect empties the FIFO.
- `FETCH_PREFETCH_EN` undefined: the IDLE/FETCH/HOLD FSM only, with no FIFO.

## Test plan
- Reset, `RESET_EIP`=0x10, zero-wait memory holding 55 at 0x10 → first `mem_req` in cycle 2 at 0x10. `ope_valid` asserts with `ope`=5500_0000, `inst_len`=1, `next_eip`=0x11.
- Bytes b8 78 56 34 12 → `ope`=b878_5634, `immidiate_data`=1234_5678, `inst_len`=5, `illegal`=0.
- Bytes 83 ec f0 → `ope`=83ec_f000, `immidiate_data`=FFFF_FFF0, `inst_len`=3. Byte 0f → `illegal`=1, `inst_len`=1.
- Hold `ope_ready`=0 for 10 cycles during a valid 89 e5 → outputs stable, `mem_req`=0 (prefetch off) or FIFO fills to 8 and `mem_req` drops (prefetch on).
- Assert `redirect` (`redirect_addr`=0x40) in the middle of an e8 fetch, with an ack in the same cycle → the partial instruction is never presented. The next `mem_addr` is 0x40, and the first delivered instruction has `inst_eip`=0x40.
- 5-byte e8 at FFFF_FFFF → reads wrap to 0..3, and `next_eip`=0000_0004.

Source files
------------

// File: rtl/inst_fetch.sv
// inst_fetch: byte-serial x86 instruction fetch and pre-decode stage feeding the execute stage.
// Ports:
//   clock_i, reset_n_i           single clock, asynchronous active-low reset
//   mem_req_o, mem_addr_o        byte read request and its address
//   mem_ack_i, mem_rdata_i       read completion, data valid in the ack cycle
//   redirect_i, redirect_addr_i  flush all in-progress work and restart at a new address
//   ope_o, immidiate_data_o      packed opcode bytes {b0,b1,b2,b3} and immediate operand
//   inst_len_o, illegal_o        instruction length (1..5) and unknown-opcode flag
//   inst_eip_o, next_eip_o       address of b0 and address following the instruction
//   ope_valid_o, ope_ready_i     output bundle handshake
// Build option FETCH_PREFETCH_EN: 8-byte prefetch FIFO with combinational head decode.
// Without it, a single-instruction IDLE/FETCH/HOLD fetcher with registered outputs is built.
module inst_fetch #(
    parameter logic [31:0] RESET_EIP = 32'h0000_0000
) (
    input  logic        clock_i,
    input  logic        reset_n_i,
    output logic        mem_req_o,
    output logic [31:0] mem_addr_o,
    input  logic        mem_ack_i,
    input  logic [7:0]  mem_rdata_i,
    input  logic        redirect_i,
    input  logic [31:0] redirect_addr_i,
    output logic [31:0] ope_o,
    output logic [31:0] immidiate_data_o,
    output logic [2:0]  inst_len_o,
    output logic [31:0] inst_eip_o,
    output logic [31:0] next_eip_o,
    output logic        illegal_o,
    output logic        ope_valid_o,
    input  logic        ope_ready_i
);
    // Instruction bytes travel as a 40-bit vector {b0, b1, b2, b3, b4}.
    function automatic logic known_op(input logic [7:0] op);
        return op == 8'h55 || op == 8'h5d || op == 8'hc3 || op == 8'h90 || op == 8'h89 ||
               op == 8'h83 || op == 8'hb8 || op == 8'he8;
    endfunction

    function automatic logic [2:0] len_of(input logic [7:0] op);
        return op == 8'h89 ? 3'd2 : op == 8'h83 ? 3'd3 :
               (op == 8'hb8 || op == 8'he8) ? 3'd5 : 3'd1;
    endfunction

    function automatic logic [31:0] ope_of(input logic [39:0] b, input logic [2:0] n);
        return b[39:8] & (n == 3'd1 ? 32'hff00_0000 : n == 3'd2 ? 32'hffff_0000 :
                          n == 3'd3 ? 32'hffff_ff00 : 32'hffff_ffff);
    endfunction

    function automatic logic [31:0] imm_of(input logic [39:0] b);
        return (b[39:32] == 8'hb8 || b[39:32] == 8'he8) ? {b[7:0], b[15:8], b[23:16], b[31:24]} :
               b[39:32] == 8'h83 ? {{24{b[23]}}, b[23:16]} : 32'h0;
    endfunction

`ifdef FETCH_PREFETCH_EN
    logic        run_q;
    logic [7:0]  fifo_q [8];
    logic [2:0]  rd_q, wr_q;
    logic [3:0]  cnt_q, cnt_d;
    logic [31:0] faddr_q, heip_q;
    logic [39:0] head_w;
    logic [2:0]  hlen_w;
    logic        push_w, pop_w;

    always_comb begin
        head_w = '0;
        for (int i = 0; i < 5; i++) head_w[39-8*i -: 8] = fifo_q[rd_q + 3'(i)];
    end

    assign hlen_w           = len_of(head_w[39:32]);
    assign ope_valid_o      = cnt_q != 4'd0 && cnt_q >= {1'b0, hlen_w};
    // No outstanding-read tracking is needed: data returns in the ack cycle.
    assign mem_req_o        = run_q && !cnt_q[3];
    assign mem_addr_o       = faddr_q;
    assign push_w           = mem_req_o && mem_ack_i;
    assign pop_w            = ope_valid_o && ope_ready_i;
    assign cnt_d            = cnt_q + {3'b0, push_w} - (pop_w ? {1'b0, hlen_w} : 4'd0);
    assign ope_o            = ope_valid_o ? ope_of(head_w, hlen_w) : 32'h0;
    assign immidiate_data_o = ope_valid_o ? imm_of(head_w) : 32'h0;
    assign inst_len_o       = ope_valid_o ? hlen_w : 3'd0;
    assign illegal_o        = ope_valid_o && !known_op(head_w[39:32]);
    assign inst_eip_o       = heip_q;
    assign next_eip_o       = heip_q + {29'd0, inst_len_o};

    always_ff @(posedge clock_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            run_q   <= 1'b0;
            rd_q    <= '0;
            wr_q    <= '0;
            cnt_q   <= '0;
            faddr_q <= RESET_EIP;
            heip_q  <= RESET_EIP;
            for (int i = 0; i < 8; i++) fifo_q[i] <= '0;
        end else if (redirect_i) begin
            run_q   <= 1'b1;
            rd_q    <= '0;
            wr_q    <= '0;
            cnt_q   <= '0;
            faddr_q <= redirect_addr_i;
            heip_q  <= redirect_addr_i;
        end else begin
            run_q <= 1'b1;
            cnt_q <= cnt_d;
            if (push_w) begin
                fifo_q[wr_q] <= mem_rdata_i;
                wr_q         <= wr_q + 3'd1;
                faddr_q      <= faddr_q + 32'd1;
            end
            if (pop_w) begin
                rd_q   <= rd_q + hlen_w;
                heip_q <= next_eip_o;
            end
        end
    end
`else
    typedef enum logic [1:0] {IDLE, FETCH, HOLD} state_t;

    state_t      state_q;
    logic        req_q, valid_q, ill_q;
    logic [2:0]  cnt_q, len_q, len_w;
    logic [31:0] addr_q, ope_q, imm_q, eip_q, neip_q;
    logic [39:0] buf_q, bytes_w;
    logic        done_w;

    // Captured bytes with the byte arriving this cycle merged in at slot cnt_q.
    always_comb begin
        bytes_w = buf_q;
        for (int i = 0; i < 5; i++)
            if (cnt_q == 3'(i)) bytes_w[39-8*i -: 8] = mem_rdata_i;
    end

    assign len_w  = len_of(bytes_w[39:32]);
    assign done_w = (cnt_q + 3'd1) == len_w;

    assign mem_req_o        = req_q;
    assign mem_addr_o       = addr_q;
    assign ope_o            = ope_q;
    assign immidiate_data_o = imm_q;
    assign inst_len_o       = len_q;
    assign inst_eip_o       = eip_q;
    assign next_eip_o       = neip_q;
    assign illegal_o        = ill_q;
    assign ope_valid_o      = valid_q;

    always_ff @(posedge clock_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q <= IDLE;
            req_q   <= 1'b0;
            valid_q <= 1'b0;
            ill_q   <= 1'b0;
            cnt_q   <= '0;
            len_q   <= '0;
            buf_q   <= '0;
            ope_q   <= '0;
            imm_q   <= '0;
            addr_q  <= RESET_EIP;
            eip_q   <= RESET_EIP;
            neip_q  <= RESET_EIP;
        end else if (redirect_i) begin
            state_q <= FETCH;
            req_q   <= 1'b1;
            valid_q <= 1'b0;
            cnt_q   <= '0;
            addr_q  <= redirect_addr_i;
        end else begin
            case (state_q)
                IDLE: begin
                    state_q <= FETCH;
                    req_q   <= 1'b1;
                end
                FETCH: if (mem_ack_i) begin
                    buf_q  <= bytes_w;
                    addr_q <= addr_q + 32'd1;
                    if (done_w) begin
                        state_q <= HOLD;
                        req_q   <= 1'b0;
                        valid_q <= 1'b1;
                        cnt_q   <= '0;
                        ope_q   <= ope_of(bytes_w, len_w);
                        imm_q   <= imm_of(bytes_w);
                        len_q   <= len_w;
                        ill_q   <= !known_op(bytes_w[39:32]);
                        // addr_q points at the final byte, cnt_q bytes past b0.
                        eip_q   <= addr_q - {29'd0, cnt_q};
                        neip_q  <= addr_q + 32'd1;
                    end else begin
                        cnt_q <= cnt_q + 3'd1;
                    end
                end
                default: if (ope_ready_i) begin
                    state_q <= FETCH;
                    req_q   <= 1'b1;
                    valid_q <= 1'b0;
                    addr_q  <= neip_q;
                end
            endcase
        end
    end
`endif
endmodule

// File: tb/tb_inst_fetch.sv
// tb_inst_fetch: directed table-driven bench for inst_fetch with a zero-wait byte memory.
module tb_inst_fetch;
    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic        mem_req, mem_ack = 1'b0, redirect = 1'b0, ope_ready = 1'b0;
    logic        illegal, ope_valid;
    logic [31:0] mem_addr, redirect_addr = '0, ope, imm, inst_eip, next_eip;
    logic [7:0]  mem_rdata = '0;
    logic [2:0]  inst_len;
    logic [7:0]  mem [256];
    logic [31:0] alog [$];
    int          n_cmp = 0, n_err = 0;

    typedef struct {
        logic [39:0] code;
        logic [31:0] ope;
        logic [31:0] imm;
        logic [2:0]  len;
        logic        ill;
    } vec_t;
    vec_t vecs [8];

    inst_fetch #(.RESET_EIP(32'h10)) dut (
        .clock_i(clock), .reset_n_i(reset_n),
        .mem_req_o(mem_req), .mem_addr_o(mem_addr), .mem_ack_i(mem_ack), .mem_rdata_i(mem_rdata),
        .redirect_i(redirect), .redirect_addr_i(redirect_addr),
        .ope_o(ope), .immidiate_data_o(imm), .inst_len_o(inst_len),
        .inst_eip_o(inst_eip), .next_eip_o(next_eip), .illegal_o(illegal),
        .ope_valid_o(ope_valid), .ope_ready_i(ope_ready)
    );

    always #5 clock = ~clock;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Zero-wait memory: answer the current request, then advance one clock.
    task automatic tick();
        mem_ack   = mem_req;
        mem_rdata = mem[mem_addr[7:0]];
        if (mem_ack) alog.push_back(mem_addr);
        @(posedge clock);
        #1;
    endtask

    task automatic load(input int a, input logic [39:0] code);
        for (int i = 0; i < 5; i++) mem[(a + i) % 256] = code[39-8*i -: 8];
    endtask

    task automatic redir(input logic [31:0] a);
        redirect = 1'b1;
        redirect_addr = a;
        tick();
        redirect = 1'b0;
    endtask

    task automatic wait_valid(output int lat);
        lat = 0;
        while (!ope_valid && lat < 30) begin
            tick();
            lat++;
        end
        chk("valid_seen", {31'd0, ope_valid}, 32'd1);
    endtask

    task automatic accept();
        ope_ready = 1'b1;
        tick();
        ope_ready = 1'b0;
    endtask

    initial begin
        int lat, nv;
        logic [31:0] a;
        vecs[0] = '{40'hb8_78_56_34_12, 32'hb878_5634, 32'h1234_5678, 3'd5, 1'b0};
        vecs[1] = '{40'h83_ec_f0_aa_aa, 32'h83ec_f000, 32'hffff_fff0, 3'd3, 1'b0};
        vecs[2] = '{40'h0f_aa_aa_aa_aa, 32'h0f00_0000, 32'h0000_0000, 3'd1, 1'b1};
        vecs[3] = '{40'h89_e5_aa_aa_aa, 32'h89e5_0000, 32'h0000_0000, 3'd2, 1'b0};
        vecs[4] = '{40'he8_10_00_00_00, 32'he810_0000, 32'h0000_0010, 3'd5, 1'b0};
        vecs[5] = '{40'hc3_aa_aa_aa_aa, 32'hc300_0000, 32'h0000_0000, 3'd1, 1'b0};
        vecs[6] = '{40'h83_c4_08_aa_aa, 32'h83c4_0800, 32'h0000_0008, 3'd3, 1'b0};
        vecs[7] = '{40'h5d_aa_aa_aa_aa, 32'h5d00_0000, 32'h0000_0000, 3'd1, 1'b0};
        for (int i = 0; i < 256; i++) mem[i] = 8'h90;
        mem[8'h10] = 8'h55;

        repeat (2) @(posedge clock);
        #1;
        chk("rst_req", {31'd0, mem_req}, 32'd0);
        chk("rst_valid", {31'd0, ope_valid}, 32'd0);
        chk("rst_illegal", {31'd0, illegal}, 32'd0);
        chk("rst_addr", mem_addr, 32'h10);
        chk("rst_eip", inst_eip, 32'h10);
        chk("rst_neip", next_eip, 32'h10);
        chk("rst_ope", ope, 32'h0);
        chk("rst_imm", imm, 32'h0);
        chk("rst_len", {29'd0, inst_len}, 32'd0);

        reset_n = 1'b1;
        chk("idle_req", {31'd0, mem_req}, 32'd0);
        tick();
        chk("first_req", {31'd0, mem_req}, 32'd1);
        chk("first_addr", mem_addr, 32'h10);
        tick();
        chk("first_valid", {31'd0, ope_valid}, 32'd1);
        chk("first_ope", ope, 32'h5500_0000);
        chk("first_len", {29'd0, inst_len}, 32'd1);
        chk("first_neip", next_eip, 32'h11);
        chk("first_eip", inst_eip, 32'h10);

        ope_ready = 1'b1;
        nv = 0;
        for (int i = 0; i < 10; i++) begin
            nv += int'(ope_valid);
            tick();
        end
        ope_ready = 1'b0;
        chk("tput_1byte", nv, 32'd5);

        for (int i = 0; i < 8; i++) begin
            a = 32'h80 + 32'(8 * i);
            load(int'(a), vecs[i].code);
            redir(a);
            wait_valid(lat);
            chk($sformatf("v%0d_ope", i), ope, vecs[i].ope);
            chk($sformatf("v%0d_imm", i), imm, vecs[i].imm);
            chk($sformatf("v%0d_len", i), {29'd0, inst_len}, {29'd0, vecs[i].len});
            chk($sformatf("v%0d_ill", i), {31'd0, illegal}, {31'd0, vecs[i].ill});
            chk($sformatf("v%0d_eip", i), inst_eip, a);
            chk($sformatf("v%0d_neip", i), next_eip, a + {29'd0, vecs[i].len});
            chk($sformatf("v%0d_latency", i), lat, {29'd0, vecs[i].len});
            accept();
        end

        load(32'h70, 40'h89_e5_aa_aa_aa);
        redir(32'h70);
        wait_valid(lat);
        for (int i = 0; i < 10; i++) begin
            chk("hold_req", {31'd0, mem_req}, 32'd0);
            chk("hold_valid", {31'd0, ope_valid}, 32'd1);
            chk("hold_ope", ope, 32'h89e5_0000);
            chk("hold_neip", next_eip, 32'h72);
            tick();
        end
        accept();

        load(32'h60, 40'he8_11_22_33_44);
        load(32'h40, 40'h89_e5_aa_aa_aa);
        redir(32'h60);
        tick();
        tick();
        chk("mid_req", {31'd0, mem_req}, 32'd1);
        chk("mid_addr", mem_addr, 32'h62);
        redir(32'h40);
        chk("redir_addr", mem_addr, 32'h40);
        chk("redir_req", {31'd0, mem_req}, 32'd1);
        chk("redir_valid", {31'd0, ope_valid}, 32'd0);
        wait_valid(lat);
        chk("redir_eip", inst_eip, 32'h40);
        chk("redir_ope", ope, 32'h89e5_0000);
        chk("redir_len", {29'd0, inst_len}, 32'd2);
        accept();

        load(255, 40'he8_04_03_02_01);
        redir(32'hffff_ffff);
        alog.delete();
        wait_valid(lat);
        chk("wrap_ope", ope, 32'he804_0302);
        chk("wrap_imm", imm, 32'h0102_0304);
        chk("wrap_eip", inst_eip, 32'hffff_ffff);
        chk("wrap_neip", next_eip, 32'h0000_0004);
        chk("wrap_nreads", alog.size(), 32'd5);
        if (alog.size() == 5) begin
            chk("wrap_rd0", alog[0], 32'hffff_ffff);
            chk("wrap_rd1", alog[1], 32'h0);
            chk("wrap_rd4", alog[4], 32'h3);
        end
        accept();

        redir(32'h80);
        tick();
        tick();
        reset_n = 1'b0;
        #1;
        chk("arst_req", {31'd0, mem_req}, 32'd0);
        chk("arst_addr", mem_addr, 32'h10);
        chk("arst_ope", ope, 32'h0);
        chk("arst_len", {29'd0, inst_len}, 32'd0);
        chk("arst_eip", inst_eip, 32'h10);
        chk("arst_valid", {31'd0, ope_valid}, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
